// File: rtl/pipe_reg_pkg.sv
// Shared types and constants for the elastic pipeline stage register.
// Bundle bit positions match the decode unit's packing.
package pipe_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } preg_state_e;

  localparam int PREG_WIDTH = 103;
  localparam int PREG_CNT_W = 8;

  localparam int B_REGWRITE = 102;
  localparam int B_MEMTOREG = 101;
  localparam int B_MEMWRITE = 100;
  localparam int B_ALUCTL_HI = 99;
  localparam int B_ALUCTL_LO = 97;
  localparam int B_ALUSRC = 96;
  localparam int B_REGDST = 95;
  localparam int B_OP1_HI = 94;
  localparam int B_OP1_LO = 63;
  localparam int B_OP2_HI = 62;
  localparam int B_OP2_LO = 31;
  localparam int B_RS_HI = 30;
  localparam int B_RS_LO = 26;
  localparam int B_RT_HI = 25;
  localparam int B_RT_LO = 21;
  localparam int B_RD_HI = 20;
  localparam int B_RD_LO = 16;
  localparam int B_IMM_HI = 15;
  localparam int B_IMM_LO = 0;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear takes priority over increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register: main + skid entry, flush, stall counter.
// Handshake outputs decode from state only.
module pipe_stage_reg
  import pipe_reg_pkg::*;
#(
  parameter int               WIDTH     = PREG_WIDTH,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0,
  parameter int               CNT_W     = PREG_CNT_W
) (
  input  logic             CLK_PReg,
  input  logic             RST_PReg,
  input  logic             CLR_PReg,
  input  logic             ValidIn,
  output logic             ReadyIn,
  input  logic [WIDTH-1:0] DataIn,
  output logic             ValidOut,
  input  logic             ReadyOut,
  output logic [WIDTH-1:0] DataOut,
  output logic [CNT_W-1:0] StallCnt,
  input  logic             CntClr
);

  preg_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign ValidOut = (state_q != EMPTY);
  assign ReadyIn  = (state_q != FULL);
  assign DataOut  = main_q;
  assign in_fire  = ValidIn & ReadyIn;
  assign out_fire = ValidOut & ReadyOut;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (CLR_PReg) begin
      state_d = EMPTY;
      main_d  = CLR_VALUE;
      skid_d  = CLR_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = DataIn;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = DataIn;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = DataIn;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = CLR_VALUE;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = CLR_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = CLR_VALUE;
          skid_d  = CLR_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_PReg or negedge RST_PReg) begin
    if (!RST_PReg) begin
      state_q <= EMPTY;
      main_q  <= CLR_VALUE;
      skid_q  <= CLR_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (CLK_PReg),
    .rst_n(RST_PReg),
    .clr  (CntClr),
    .inc  (ValidOut & ~ReadyOut),
    .cnt  (StallCnt)
  );

endmodule
